// File: rtl/hazard_tracker_pkg.sv
// rtl/hazard_tracker_pkg.sv - shared opcode, forward-select and entry types for the hazard tracker
//
// Shared definitions:
//   OP_*            7-bit major opcodes used by the field decoder
//   FWD_REGFILE     forward-select value meaning "read the register file"
//   FWD_ENTRY_BASE  forward-select value of entry 0 (entry k -> k + FWD_ENTRY_BASE)
//   entry_t         one tracked in-flight writer {valid, rd, is_load}
//   dec_t           decoded register fields of one instruction word

package hazard_tracker_pkg;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_CSR       = 7'b1110011;
    localparam logic [6:0] OP_NOOP      = 7'b0000000;

    localparam int FWD_REGFILE    = 0;
    localparam int FWD_ENTRY_BASE = 1;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } entry_t;

    typedef struct packed {
        logic       has_rd;
        logic       has_rs1;
        logic       has_rs2;
        logic       is_load;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } dec_t;

endpackage

// File: rtl/inst_reg_decode.sv
// rtl/inst_reg_decode.sv - combinational register-field decode of one instruction word
//
// Ports:
//   inst  in   32-bit instruction word
//   dec   out  {has_rd, has_rs1, has_rs2, is_load, rd, rs1, rs2}

module inst_reg_decode
    import hazard_tracker_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0] opcode;
    assign opcode = inst[6:0];

    // Immediate / funct7 bits and the low funct3 bits carry no register information.
    logic unused_bits;
    assign unused_bits = ^{inst[31:25], inst[13:12]};

    always_comb begin
        dec         = '0;
        dec.rd      = inst[11:7];
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.is_load = (opcode == OP_LOAD);
        dec.has_rd  = !((opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_NOOP));
        dec.has_rs2 = (opcode == OP_ARI_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_NOOP: dec.has_rs1 = 1'b0;
            // funct3[2] set selects the immediate (zimm) CSR forms, which read no rs1
            OP_CSR:                            dec.has_rs1 = ~inst[14];
            default:                           dec.has_rs1 = 1'b1;
        endcase
    end

endmodule

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - in-flight writer tracking, forward-select and load-use stall
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   issue_valid  in   decode-stage instruction valid
//   issue_inst   in   decode-stage instruction word
//   flush        in   drop the decode instruction and invalidate all entries
//   fwd_sel_rs1  out  0 = regfile, k = forward from entry k-1
//   fwd_sel_rs2  out  same encoding for rs2
//   stall_out    out  load-use stall, hold decode this cycle
//   stall_cnt    out  saturating count of stall cycles

module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter  int DEPTH          = 2,
    parameter  int LOAD_FWD_STAGE = 1,
    localparam int SEL_W          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [31:0]      issue_inst,
    input  logic             flush,
    output logic [SEL_W-1:0] fwd_sel_rs1,
    output logic [SEL_W-1:0] fwd_sel_rs2,
    output logic             stall_out,
    output logic [15:0]      stall_cnt
);

    dec_t dec_iss;
    dec_t dec_wr;

    // Source-side decode drives matching; destination-side decode drives the entry-0 write.
    inst_reg_decode u_dec_iss (
        .inst (issue_inst),
        .dec  (dec_iss)
    );

    inst_reg_decode u_dec_wr (
        .inst (issue_inst),
        .dec  (dec_wr)
    );

    logic unused_dec;
    assign unused_dec = ^{dec_iss.has_rd, dec_iss.is_load, dec_iss.rd,
                          dec_wr.has_rs1, dec_wr.has_rs2, dec_wr.rs1, dec_wr.rs2};

    entry_t           ent [DEPTH];
    entry_t           new_ent;
    logic             wr_en;
    logic [DEPTH-1:0] match_rs1;
    logic [DEPTH-1:0] match_rs2;
    logic [DEPTH-1:0] early_ld_rs1;
    logic [DEPTH-1:0] early_ld_rs2;
    logic             stall_rs1;
    logic             stall_rs2;

    // A stalled instruction is replayed next cycle, so it must not be recorded now.
    assign wr_en = issue_valid & ~stall_out & ~flush & dec_wr.has_rd & (dec_wr.rd != 5'd0);

    always_comb begin
        new_ent = '0;
        if (wr_en) begin
            new_ent.valid   = 1'b1;
            new_ent.rd      = dec_wr.rd;
            new_ent.is_load = dec_wr.is_load;
        end
    end

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_ent
            // Load data only becomes forwardable once it has reached LOAD_FWD_STAGE.
            localparam bit EARLY = (k < LOAD_FWD_STAGE);

            entry_t q;
            entry_t d;

            if (k == 0) begin : g_head
                assign d = new_ent;
            end else begin : g_tail
                assign d = ent[k-1];
            end

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    q <= '0;
                end else begin
                    q <= d;
                end
            end

            assign ent[k] = q;

            assign match_rs1[k] = q.valid & (q.rd == dec_iss.rs1) & dec_iss.has_rs1
                                & issue_valid & (dec_iss.rs1 != 5'd0);
            assign match_rs2[k] = q.valid & (q.rd == dec_iss.rs2) & dec_iss.has_rs2
                                & issue_valid & (dec_iss.rs2 != 5'd0);
            assign early_ld_rs1[k] = q.is_load & EARLY;
            assign early_ld_rs2[k] = q.is_load & EARLY;
        end
    endgenerate

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        fwd_sel_rs1 = SEL_W'(FWD_REGFILE);
        fwd_sel_rs2 = SEL_W'(FWD_REGFILE);
        stall_rs1   = 1'b0;
        stall_rs2   = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_rs1[k]) begin
                fwd_sel_rs1 = SEL_W'(k + FWD_ENTRY_BASE);
                stall_rs1   = early_ld_rs1[k];
            end
            if (match_rs2[k]) begin
                fwd_sel_rs2 = SEL_W'(k + FWD_ENTRY_BASE);
                stall_rs2   = early_ld_rs2[k];
            end
        end
    end

    assign stall_out = (stall_rs1 | stall_rs2) & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_out && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - self-checking bench for hazard_tracker

module tb_hazard_tracker;

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011, LUI = 7'b0110111;
    localparam logic [6:0] AUI = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, CSR = 7'b1110011, NP = 7'b0000000;
    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_inst = 32'h0;
    logic        flush = 1'b0;

    logic [1:0]  a_s1, a_s2, e_s1, e_s2;
    logic [0:0]  b_s1, b_s2;
    logic [2:0]  c_s1, c_s2, d_s1, d_s2;
    logic        a_st, b_st, c_st, d_st, e_st;
    logic [15:0] a_cnt, b_cnt, c_cnt, d_cnt, e_cnt;

    always #5 clk = ~clk;

    hazard_tracker #(.DEPTH(2), .LOAD_FWD_STAGE(1)) dut_a (.clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_inst(issue_inst), .flush(flush), .fwd_sel_rs1(a_s1), .fwd_sel_rs2(a_s2), .stall_out(a_st), .stall_cnt(a_cnt));
    hazard_tracker #(.DEPTH(1), .LOAD_FWD_STAGE(1)) dut_b (.clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_inst(issue_inst), .flush(flush), .fwd_sel_rs1(b_s1), .fwd_sel_rs2(b_s2), .stall_out(b_st), .stall_cnt(b_cnt));
    hazard_tracker #(.DEPTH(4), .LOAD_FWD_STAGE(2)) dut_c (.clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_inst(issue_inst), .flush(flush), .fwd_sel_rs1(c_s1), .fwd_sel_rs2(c_s2), .stall_out(c_st), .stall_cnt(c_cnt));
    hazard_tracker #(.DEPTH(4), .LOAD_FWD_STAGE(4)) dut_d (.clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_inst(issue_inst), .flush(flush), .fwd_sel_rs1(d_s1), .fwd_sel_rs2(d_s2), .stall_out(d_st), .stall_cnt(d_cnt));
    hazard_tracker #(.DEPTH(2), .LOAD_FWD_STAGE(0)) dut_e (.clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_inst(issue_inst), .flush(flush), .fwd_sel_rs1(e_s1), .fwd_sel_rs2(e_s2), .stall_out(e_st), .stall_cnt(e_cnt));

    // Reference model: per instance, a list of writers ordered youngest first.
    int  md[NI] = '{2, 1, 4, 4, 2};
    int  ml[NI] = '{1, 1, 2, 4, 0};
    int  m_rd[NI][4];
    bit  m_ld[NI][4];
    bit  m_v[NI][4];
    int  m_cnt[NI];
    int  tests = 0;
    int  fails = 0;
    bit  chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic void decode(input logic [31:0] i, output bit hrd, output bit hrs1, output bit hrs2,
                                   output bit ld, output int rd, output int rs1, output int rs2);
        logic [6:0] op;
        op   = i[6:0];
        hrd  = !(op == BR || op == ST || op == NP);
        if (op == LUI || op == AUI || op == JAL || op == NP) hrs1 = 0;
        else if (op == CSR) hrs1 = !i[14];
        else hrs1 = 1;
        hrs2 = (op == RT || op == ST || op == BR);
        ld   = (op == LD);
        rd   = int'(i[11:7]);
        rs1  = int'(i[19:15]);
        rs2  = int'(i[24:20]);
    endfunction

    function automatic int youngest(input int n, input int src);
        for (int k = 0; k < md[n]; k++)
            if (m_v[n][k] && m_rd[n][k] == src) return k;
        return -1;
    endfunction

    function automatic void expect_out(input int n, output int s1, output int s2, output bit st);
        bit hrd, h1, h2, ld;
        int rd, r1, r2, k1, k2;
        decode(issue_inst, hrd, h1, h2, ld, rd, r1, r2);
        k1 = (issue_valid && h1 && r1 != 0) ? youngest(n, r1) : -1;
        k2 = (issue_valid && h2 && r2 != 0) ? youngest(n, r2) : -1;
        s1 = k1 + 1;
        s2 = k2 + 1;
        st = 0;
        if (k1 >= 0 && m_ld[n][k1] && k1 < ml[n]) st = 1;
        if (k2 >= 0 && m_ld[n][k2] && k2 < ml[n]) st = 1;
        if (flush) st = 0;
    endfunction

    task automatic update_model();
        bit hrd, h1, h2, ld, st;
        int rd, r1, r2, s1, s2;
        decode(issue_inst, hrd, h1, h2, ld, rd, r1, r2);
        for (int n = 0; n < NI; n++) begin
            expect_out(n, s1, s2, st);
            if (rst || flush) begin
                for (int k = 0; k < 4; k++) begin m_v[n][k] = 0; m_rd[n][k] = 0; m_ld[n][k] = 0; end
                if (rst) m_cnt[n] = 0;
            end else begin
                for (int k = md[n] - 1; k > 0; k--) begin
                    m_v[n][k] = m_v[n][k-1]; m_rd[n][k] = m_rd[n][k-1]; m_ld[n][k] = m_ld[n][k-1];
                end
                m_v[n][0]  = issue_valid && !st && hrd && rd != 0;
                m_rd[n][0] = rd;
                m_ld[n][0] = ld;
            end
            if (!rst && st && m_cnt[n] < 65535) m_cnt[n]++;
        end
        if (rst) chk_en = 1;
    endtask

    task automatic get_dut(input int n, output logic [31:0] s1, output logic [31:0] s2,
                           output logic [31:0] st, output logic [31:0] cnt);
        case (n)
            0: begin s1 = 32'(a_s1); s2 = 32'(a_s2); st = 32'(a_st); cnt = 32'(a_cnt); end
            1: begin s1 = 32'(b_s1); s2 = 32'(b_s2); st = 32'(b_st); cnt = 32'(b_cnt); end
            2: begin s1 = 32'(c_s1); s2 = 32'(c_s2); st = 32'(c_st); cnt = 32'(c_cnt); end
            3: begin s1 = 32'(d_s1); s2 = 32'(d_s2); st = 32'(d_st); cnt = 32'(d_cnt); end
            default: begin s1 = 32'(e_s1); s2 = 32'(e_s2); st = 32'(e_st); cnt = 32'(e_cnt); end
        endcase
    endtask

    // Compare process: every DUT against the model on every cycle after reset.
    initial begin
        logic [31:0] s1, s2, st, cnt;
        int es1, es2;
        bit est;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int n = 0; n < NI; n++) begin
                    get_dut(n, s1, s2, st, cnt);
                    expect_out(n, es1, es2, est);
                    chk($sformatf("model_sel1_i%0d", n), s1, 32'(es1));
                    chk($sformatf("model_sel2_i%0d", n), s2, 32'(es2));
                    chk($sformatf("model_stall_i%0d", n), st, 32'(est));
                    chk($sformatf("model_cnt_i%0d", n), cnt, 32'(m_cnt[n]));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] inst, input logic fl, input logic r);
        @(posedge clk);
        update_model();
        #1;
        issue_valid = v;
        issue_inst  = inst;
        flush       = fl;
        rst         = r;
        @(negedge clk);
    endtask

    function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2, input int rs1, input int rd);
        return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), RT};
    endfunction

    function automatic logic [31:0] i_t(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction

    logic [6:0] ops[11] = '{LD, ST, BR, LUI, AUI, JAL, JALR, RT, IT, CSR, NP};

    initial begin
        logic [31:0] r, ri;
        drive(0, 32'h0, 0, 1);
        drive(0, 32'h0, 0, 0);
        chk("reset_sel1", 32'(a_s1), 0); chk("reset_sel2", 32'(a_s2), 0);
        chk("reset_stall", 32'(a_st), 0); chk("reset_cnt", 32'(a_cnt), 0);

        // back-to-back ALU dependency
        drive(1, r_t(0, 2, 1, 5), 0, 0);
        drive(1, r_t(0, 5, 5, 6), 0, 0);
        chk("b2b_sel1", 32'(a_s1), 1); chk("b2b_sel2", 32'(a_s2), 1); chk("b2b_stall", 32'(a_st), 0);
        drive(0, 32'h0, 0, 0); drive(0, 32'h0, 0, 0);

        // distance-two dependency, and DEPTH=1 misses it
        drive(1, r_t(0, 2, 1, 5), 0, 0);
        drive(1, 32'h0, 0, 0);
        drive(1, r_t(7'b0100000, 3, 5, 7), 0, 0);
        chk("dist2_sel1", 32'(a_s1), 2); chk("dist2_sel2", 32'(a_s2), 0); chk("dist2_d1_sel1", 32'(b_s1), 0);
        drive(0, 32'h0, 0, 0); drive(0, 32'h0, 0, 0);

        // load-use
        drive(1, i_t(0, 1, 3'b010, 5, LD), 0, 0);
        drive(1, r_t(0, 0, 5, 6), 0, 0);
        chk("lu_stall", 32'(a_st), 1); chk("lu_sel1", 32'(a_s1), 1); chk("lu_lfs0_stall", 32'(e_st), 0);
        drive(1, r_t(0, 0, 5, 6), 0, 0);
        chk("lu2_stall", 32'(a_st), 0); chk("lu2_sel1", 32'(a_s1), 2); chk("lu2_cnt", 32'(a_cnt), 1);
        drive(0, 32'h0, 0, 0); drive(0, 32'h0, 0, 0);

        // x0 never forwards
        drive(1, i_t(1, 0, 3'b000, 0, IT), 0, 0);
        drive(1, r_t(0, 0, 0, 3), 0, 0);
        chk("x0_sel1", 32'(a_s1), 0); chk("x0_sel2", 32'(a_s2), 0);
        drive(1, {20'h12345, 5'd5, LUI}, 0, 0);
        drive(1, {20'h12345, 5'd6, LUI}, 0, 0);
        chk("lui_sel1", 32'(a_s1), 0);
        drive(0, 32'h0, 0, 0); drive(0, 32'h0, 0, 0);

        // youngest writer wins
        drive(1, i_t(1, 0, 3'b000, 5, IT), 0, 0);
        drive(1, i_t(2, 0, 3'b000, 5, IT), 0, 0);
        drive(1, r_t(0, 5, 5, 9), 0, 0);
        chk("young_sel1", 32'(a_s1), 1); chk("young_sel2", 32'(a_s2), 1);
        drive(0, 32'h0, 0, 0); drive(0, 32'h0, 0, 0);

        // flush kills a would-be stall and empties the tracker
        drive(1, i_t(1, 0, 3'b000, 5, IT), 0, 0);
        drive(1, i_t(0, 1, 3'b010, 5, LD), 0, 0);
        drive(1, r_t(0, 5, 5, 9), 1, 0);
        chk("flush_stall", 32'(a_st), 0); chk("flush_sel1", 32'(a_s1), 1);
        drive(1, r_t(0, 5, 5, 9), 0, 0);
        chk("post_flush_sel1", 32'(a_s1), 0); chk("post_flush_sel2", 32'(a_s2), 0);
        chk("post_flush_stall", 32'(a_st), 0);
        drive(0, 32'h0, 0, 0); drive(0, 32'h0, 0, 0);

        // reset during a load-use stall
        drive(1, i_t(0, 1, 3'b010, 5, LD), 0, 0);
        drive(1, r_t(0, 0, 5, 6), 0, 1);
        chk("rst_stall_pre", 32'(a_st), 1);
        drive(1, r_t(0, 0, 5, 6), 0, 0);
        chk("rst_stall_post", 32'(a_st), 0); chk("rst_cnt", 32'(a_cnt), 0);
        chk("rst_sel1", 32'(a_s1), 0); chk("rst_sel2", 32'(a_s2), 0);

        // randomized traffic on a small register set so dependencies are frequent
        for (int c = 0; c < 3000; c++) begin
            r  = $urandom;
            ri = {r[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[14:12],
                  5'($urandom_range(0, 7)), ops[$urandom_range(0, 10)]};
            drive(($urandom % 4) != 0, ri, ($urandom % 16) == 0, ($urandom % 100) == 0);
        end

        // saturation: self-dependent load stalls four cycles out of five on DEPTH=4, LFS=4
        drive(0, 32'h0, 0, 1);
        for (int c = 0; c < 82000; c++) drive(1, i_t(0, 5, 3'b010, 5, LD), 0, 0);
        chk("sat_cnt", 32'(d_cnt), 32'hFFFF);
        for (int c = 0; c < 5; c++) drive(1, i_t(0, 5, 3'b010, 5, LD), 0, 0);
        chk("sat_hold_cnt", 32'(d_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
